stream_pkt_gen: RTL

//  Packet source (transmitter) for the keep/last valid-ready stream consumed by the width resizer slave port.

---
 rtl/stream_pkg.sv | 31 +++
 rtl/stream_beat_pack.sv | 51 +++++
 rtl/stream_pkt_gen.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream packet generator.
// Lane-mask helper supports an optional hole lane (used when KEEP_HOLE_EN is defined).
package stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int MAX_LANES  = 32;
  localparam int BEAT_IDX_W = 8;

  // Lowest n lanes set, skipping the hole lane when hole_en is high.
  function automatic logic [MAX_LANES-1:0] lane_mask(
    input int unsigned n,
    input int unsigned hole,
    input logic        hole_en
  );
    int unsigned cnt;
    lane_mask = '0;
    cnt       = 32'd0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      if ((cnt < n) && !(hole_en && (hole == i))) begin
        lane_mask[i] = 1'b1;
        cnt          = cnt + 32'd1;
      end
    end
  endfunction

endpackage

// File: rtl/stream_beat_pack.sv
// Combinational beat packer: places consecutive elements into lanes for one beat.
// With KEEP_HOLE_EN defined one lane per beat (hole_i) is left empty.
module stream_beat_pack
  import stream_pkg::*;
#(
  parameter int KEEP_WIDTH   = 3,
  parameter int T_DATA_WIDTH = 8,
  parameter int LEN_WIDTH    = 16
) (
  input  logic [T_DATA_WIDTH-1:0] seed_i,
  input  logic [LEN_WIDTH-1:0]    rem_i,
`ifdef KEEP_HOLE_EN
  input  logic [BEAT_IDX_W-1:0]   hole_i,
`endif
  output logic [KEEP_WIDTH-1:0]   keep_o,
  output logic [T_DATA_WIDTH-1:0] data_o [KEEP_WIDTH],
  output logic [LEN_WIDTH-1:0]    used_o,
  output logic                    last_o
);

`ifdef KEEP_HOLE_EN
  localparam int LANES = KEEP_WIDTH - 1;
`else
  localparam int LANES = KEEP_WIDTH;
`endif

  logic [T_DATA_WIDTH-1:0] w_k;

  assign last_o = (rem_i <= LEN_WIDTH'(LANES));
  assign used_o = last_o ? rem_i : LEN_WIDTH'(LANES);

`ifdef KEEP_HOLE_EN
  assign keep_o = KEEP_WIDTH'(lane_mask(32'(used_o), 32'(hole_i), 1'b1));
`else
  assign keep_o = KEEP_WIDTH'(lane_mask(32'(used_o), 32'd0, 1'b0));
`endif

  // Kept lanes take ascending elements; the rest drive zero.
  always_comb begin
    w_k = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      if (keep_o[i]) begin
        data_o[i] = seed_i + w_k;
        w_k       = w_k + T_DATA_WIDTH'(1);
      end else begin
        data_o[i] = '0;
      end
    end
  end

endmodule

// File: rtl/stream_pkt_gen.sv
// Packet source: one {length, seed} command becomes one keep/last stream packet.
// Optional hole-lane pattern enabled by defining KEEP_HOLE_EN.
module stream_pkt_gen
  import stream_pkg::*;
#(
  parameter int KEEP_WIDTH   = 3,
  parameter int T_DATA_WIDTH = 8,
  parameter int LEN_WIDTH    = 16,
  parameter int GAP_CYCLES   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [LEN_WIDTH-1:0]    cmd_len_i,
  input  logic [T_DATA_WIDTH-1:0] cmd_seed_i,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic                    m_last_o,
  output logic [KEEP_WIDTH-1:0]   m_keep_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o [KEEP_WIDTH],
  output logic                    busy_o,
  output logic                    done_o,
  output logic [15:0]             pkt_cnt_o
);

  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  state_t                  r_state;
  logic [LEN_WIDTH-1:0]    r_rem;
  logic [T_DATA_WIDTH-1:0] r_seed;
  logic [GAP_W-1:0]        r_gap;
  logic                    r_valid;
  logic                    r_last;
  logic [KEEP_WIDTH-1:0]   r_keep;
  logic [T_DATA_WIDTH-1:0] r_data [KEEP_WIDTH];
  logic                    r_done;
  logic [15:0]             r_pkt_cnt;

  logic [T_DATA_WIDTH-1:0] w_p_seed;
  logic [LEN_WIDTH-1:0]    w_p_rem;
  logic [KEEP_WIDTH-1:0]   w_keep;
  logic [T_DATA_WIDTH-1:0] w_data [KEEP_WIDTH];
  logic [LEN_WIDTH-1:0]    w_used;
  logic                    w_last;
  logic                    w_load;

  // In IDLE the packer works on the incoming command so the first beat lands one cycle later.
  assign w_p_seed = (r_state == ST_IDLE) ? cmd_seed_i : r_seed;
  assign w_p_rem  = (r_state == ST_IDLE) ? cmd_len_i  : r_rem;
  assign w_load   = ((r_state == ST_IDLE) && cmd_valid_i && (cmd_len_i != '0)) ||
                    ((r_state == ST_SEND) && m_ready_i && !r_last);

`ifdef KEEP_HOLE_EN
  logic [BEAT_IDX_W-1:0] r_beat_idx;
  logic [BEAT_IDX_W-1:0] w_p_hole;
  assign w_p_hole = (r_state == ST_IDLE) ? '0 : r_beat_idx;

  // Hole lane rotates one position per beat and restarts with every packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat_idx <= '0;
    end else if (w_load) begin
      r_beat_idx <= (w_p_hole == BEAT_IDX_W'(KEEP_WIDTH - 1)) ? '0 : w_p_hole + BEAT_IDX_W'(1);
    end else begin
      r_beat_idx <= r_beat_idx;
    end
  end
`endif

  stream_beat_pack #(
    .KEEP_WIDTH  (KEEP_WIDTH),
    .T_DATA_WIDTH(T_DATA_WIDTH),
    .LEN_WIDTH   (LEN_WIDTH)
  ) u_pack (
    .seed_i(w_p_seed),
    .rem_i (w_p_rem),
`ifdef KEEP_HOLE_EN
    .hole_i(w_p_hole),
`endif
    .keep_o(w_keep),
    .data_o(w_data),
    .used_o(w_used),
    .last_o(w_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_rem     <= '0;
      r_seed    <= '0;
      r_gap     <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_keep    <= '0;
      r_data    <= '{default: '0};
      r_done    <= 1'b0;
      r_pkt_cnt <= 16'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid_i && (cmd_len_i == '0)) begin
            r_done <= 1'b1;
          end else if (cmd_valid_i) begin
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (m_ready_i && r_last) begin
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_keep    <= '0;
            r_data    <= '{default: '0};
            r_done    <= 1'b1;
            r_pkt_cnt <= r_pkt_cnt + 16'd1;
            if (GAP_CYCLES > 0) begin
              r_gap   <= GAP_W'(GAP_CYCLES);
              r_state <= ST_GAP;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          r_gap <= r_gap - GAP_W'(1);
          if (r_gap <= GAP_W'(1)) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_load) begin
        r_valid <= 1'b1;
        r_last  <= w_last;
        r_keep  <= w_keep;
        r_data  <= w_data;
        r_rem   <= w_p_rem - w_used;
        r_seed  <= w_p_seed + T_DATA_WIDTH'(w_used);
      end
    end
  end

  assign cmd_ready_o = (r_state == ST_IDLE);
  assign busy_o      = (r_state != ST_IDLE);
  assign m_valid_o   = r_valid;
  assign m_last_o    = r_last;
  assign m_keep_o    = r_keep;
  assign m_data_o    = r_data;
  assign done_o      = r_done;
  assign pkt_cnt_o   = r_pkt_cnt;

endmodule
